// File: rtl/if_fetch_ctrl.sv
// IF0 fetch sequencer: owns the fetch PC, issues ICache requests and handles redirects/stalls.
// Optional performance counters are built only when IF_PERF_CNT_EN is defined.
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h1C000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_from_Load,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_PC,
   input  logic        icache_req_ready,
   output logic        ICache_req_valid,
   output logic [31:0] IF0_PC,
   output logic        ICache_valid,
   output logic        IF0_IF1_stall_from_Load,
   output logic        flush,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_miss_cnt
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_MISS  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]  r_state;
   logic [1:0]  w_stateNext;
   logic [31:0] r_pc;
   logic [31:0] w_pcNext;
   logic        r_valid;
   logic        w_validNext;
   logic        r_reqPending;
   logic        w_reqPendingNext;
   logic [31:0] w_redirTarget;
   logic [31:0] w_pcInc;

   assign w_redirTarget = redirect_PC & ~32'd3;
   assign w_pcInc       = r_pc + 32'd4;

   assign ICache_req_valid        = (r_state == S_FETCH) || (r_state == S_MISS);
   assign flush                   = redirect_valid;
   assign IF0_IF1_stall_from_Load = stall_from_Load;
   assign IF0_PC                  = r_pc;
   assign ICache_valid            = r_valid;

   // A request is still pending at the ICache when it was presented but not accepted and
   // not replaced by a redirect; a redirect then has to wait for that refill in DRAIN.
   assign w_reqPendingNext = ICache_req_valid && !icache_req_ready && !redirect_valid;

   always_comb begin
      w_stateNext = r_state;
      w_pcNext    = r_pc;
      w_validNext = r_valid;
      case (r_state)
         S_IDLE: begin
            w_stateNext = S_FETCH;
            w_validNext = 1'b0;
            if (redirect_valid) begin
               w_pcNext = w_redirTarget;
            end
         end
         S_FETCH: begin
            if (redirect_valid) begin
               w_pcNext    = w_redirTarget;
               w_validNext = 1'b0;
               if (!icache_req_ready && r_reqPending) begin
                  w_stateNext = S_DRAIN;
               end
            end else if (stall_from_Load) begin
               w_stateNext = S_FETCH;
            end else if (icache_req_ready) begin
               w_pcNext    = w_pcInc;
               w_validNext = 1'b1;
            end else begin
               w_stateNext = S_MISS;
               w_validNext = 1'b0;
            end
         end
         S_MISS: begin
            w_validNext = 1'b0;
            if (redirect_valid) begin
               w_pcNext    = w_redirTarget;
               w_stateNext = icache_req_ready ? S_FETCH : S_DRAIN;
            end else if (!stall_from_Load && icache_req_ready) begin
               w_pcNext    = w_pcInc;
               w_validNext = 1'b1;
               w_stateNext = S_FETCH;
            end
         end
         default: begin
            // The refill for the abandoned PC is discarded; only the redirect PC survives.
            w_validNext = 1'b0;
            if (redirect_valid) begin
               w_pcNext = w_redirTarget;
            end else if (icache_req_ready) begin
               w_stateNext = S_FETCH;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_valid      <= 1'b0;
         r_reqPending <= 1'b0;
      end else begin
         r_state      <= w_stateNext;
         r_pc         <= w_pcNext;
         r_valid      <= w_validNext;
         r_reqPending <= w_reqPendingNext;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic        w_advance;
   logic [31:0] r_fetchCnt;
   logic [31:0] r_missCnt;

   assign w_advance = ICache_req_valid && !redirect_valid && !stall_from_Load && icache_req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetchCnt <= 32'd0;
         r_missCnt  <= 32'd0;
      end else begin
         if (w_advance) begin
            r_fetchCnt <= r_fetchCnt + 32'd1;
         end
         if ((r_state == S_MISS) || (r_state == S_DRAIN)) begin
            r_missCnt <= r_missCnt + 32'd1;
         end
      end
   end

   assign perf_fetch_cnt = r_fetchCnt;
   assign perf_miss_cnt  = r_missCnt;
`else
   assign perf_fetch_cnt = 32'd0;
   assign perf_miss_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed testbench for if_fetch_ctrl: a scoreboard queue holds the expected IF0_PC/ICache_valid
// for each driven cycle and is drained after the clock edge that produces it.
module tb_if_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        stall_from_Load;
   logic        redirect_valid;
   logic [31:0] redirect_PC;
   logic        icache_req_ready;
   logic        ICache_req_valid;
   logic [31:0] IF0_PC;
   logic        ICache_valid;
   logic        IF0_IF1_stall_from_Load;
   logic        flush;
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_miss_cnt;

   typedef struct {
      logic [31:0] pc;
      logic        valid;
      string       tag;
   } expT;

   expT expQ[$];
   int  checkCount = 0;
   int  failCount  = 0;

`ifdef IF_PERF_CNT_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   if_fetch_ctrl #(.RESET_PC(32'h1C000000)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .stall_from_Load         (stall_from_Load),
      .redirect_valid          (redirect_valid),
      .redirect_PC             (redirect_PC),
      .icache_req_ready        (icache_req_ready),
      .ICache_req_valid        (ICache_req_valid),
      .IF0_PC                  (IF0_PC),
      .ICache_valid            (ICache_valid),
      .IF0_IF1_stall_from_Load (IF0_IF1_stall_from_Load),
      .flush                   (flush),
      .perf_fetch_cnt          (perf_fetch_cnt),
      .perf_miss_cnt           (perf_miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts, and reports tag/observed/expected on a miss.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs (called at a negedge), checks the combinational outputs,
   // queues the registered result and compares it just after the next posedge.
   task automatic applyStimulus(input string tag, input logic redir, input logic [31:0] rpc,
                                input logic stall, input logic rdy, input logic expReq,
                                input logic [31:0] expPc, input logic expValid);
      expT e;
      redirect_valid   = redir;
      redirect_PC      = rpc;
      stall_from_Load  = stall;
      icache_req_ready = rdy;
      #1;
      checkOutput({tag, ".req_valid"}, {31'd0, ICache_req_valid}, {31'd0, expReq});
      checkOutput({tag, ".flush"}, {31'd0, flush}, {31'd0, redir});
      checkOutput({tag, ".stall_out"}, {31'd0, IF0_IF1_stall_from_Load}, {31'd0, stall});
      expQ.push_back('{pc: expPc, valid: expValid, tag: tag});
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      checkOutput({e.tag, ".pc"}, IF0_PC, e.pc);
      checkOutput({e.tag, ".valid"}, {31'd0, ICache_valid}, {31'd0, e.valid});
      @(negedge clk);
   endtask

   initial begin
      rst              = 1'b1;
      stall_from_Load  = 1'b0;
      redirect_valid   = 1'b0;
      redirect_PC      = 32'd0;
      icache_req_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.pc", IF0_PC, 32'h1C000000);
      checkOutput("reset.valid", {31'd0, ICache_valid}, 32'd0);
      checkOutput("reset.req_valid", {31'd0, ICache_req_valid}, 32'd0);
      checkOutput("reset.flush", {31'd0, flush}, 32'd0);
      checkOutput("reset.fetch_cnt", perf_fetch_cnt, 32'd0);
      checkOutput("reset.miss_cnt", perf_miss_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Streaming fetch with ready held high
      applyStimulus("idle",   1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h1C000000, 1'b0);
      applyStimulus("seq0",   1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1C000004, 1'b1);
      applyStimulus("seq1",   1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1C000008, 1'b1);
      applyStimulus("seq2",   1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1C00000C, 1'b1);
      applyStimulus("seq3",   1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1C000010, 1'b1);

      // Three not-ready cycles at 1C000010
      applyStimulus("miss0",  1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h1C000010, 1'b0);
      applyStimulus("miss1",  1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h1C000010, 1'b0);
      applyStimulus("miss2",  1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h1C000010, 1'b0);
      applyStimulus("missok", 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1C000014, 1'b1);
      checkOutput("cnt.fetch", perf_fetch_cnt, PERF_EN ? 32'd5 : 32'd0);
      checkOutput("cnt.miss", perf_miss_cnt, PERF_EN ? 32'd3 : 32'd0);

      // Redirect in FETCH with misaligned target; redirect beats the accepted fetch
      applyStimulus("redir",  1'b1, 32'h1C000103, 1'b0, 1'b1, 1'b1, 32'h1C000100, 1'b0);
      applyStimulus("postrd", 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1C000104, 1'b1);

      // Redirect during MISS: old refill drains before fetching the target
      applyStimulus("dmiss",  1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h1C000104, 1'b0);
      applyStimulus("dredir", 1'b1, 32'h1C000200, 1'b0, 1'b0, 1'b1, 32'h1C000200, 1'b0);
      applyStimulus("drain0", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h1C000200, 1'b0);
      applyStimulus("drain1", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h1C000200, 1'b0);
      applyStimulus("dfetch", 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1C000204, 1'b1);

      // Load-use stall freezes fetch; a redirect still wins over the stall
      applyStimulus("stall0", 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h1C000204, 1'b1);
      applyStimulus("stall1", 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h1C000204, 1'b1);
      applyStimulus("stallrd",1'b1, 32'h1C000300, 1'b1, 1'b1, 1'b1, 32'h1C000300, 1'b0);
      applyStimulus("poststl",1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1C000304, 1'b1);

      // Redirect together with ready while in MISS goes straight to FETCH
      applyStimulus("mr0",    1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h1C000304, 1'b0);
      applyStimulus("mr1",    1'b1, 32'h1C000400, 1'b0, 1'b1, 1'b1, 32'h1C000400, 1'b0);
      applyStimulus("mr2",    1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1C000404, 1'b1);

      // PC wrap-around at the top of the address space
      applyStimulus("wrapset",1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0);
      applyStimulus("wrap",   1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h00000000, 1'b1);
      applyStimulus("wmiss0", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0);
      applyStimulus("wmiss1", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0);

      // Asynchronous reset asserted mid-cycle while in MISS
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midrst.pc", IF0_PC, 32'h1C000000);
      checkOutput("midrst.valid", {31'd0, ICache_valid}, 32'd0);
      checkOutput("midrst.req_valid", {31'd0, ICache_req_valid}, 32'd0);
      checkOutput("midrst.fetch_cnt", perf_fetch_cnt, 32'd0);
      checkOutput("midrst.miss_cnt", perf_miss_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus("ridle",  1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h1C000000, 1'b0);
      applyStimulus("rseq0",  1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1C000004, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

- Front-end fetch sequencer that owns the IF0 program counter and drives the IF0→IF1 pipeline register.
- Issues one ICache request per cycle and advances the PC on acceptance. Inserts bubbles (ICache_valid=0) on ICache not-ready.
- Handles branch/exception redirects, including one that arrives while an ICache refill is in flight. Forwards the load-use stall to the IF0/IF1 register.

## Interface
- RESET_PC, 32'h1C000000, PC loaded on reset (word aligned).
- clk  in  1  core clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall_from_Load  in  1  load-use stall from decode; freezes fetch.
- redirect_valid  in  1  branch/exception redirect from EX, one-cycle pulse.
- redirect_PC  in  32  redirect target; bits [1:0] forced to 0 internally.
- icache_req_ready  in  1  ICache accepts the current request this cycle (hit or refill complete).
- ICache_req_valid  out  1  request valid to ICache.
- IF0_PC  out  32  fetch PC (ICache address, IF0_IF1_PC_in).
- ICache_valid  out  1  slot-valid to IF0_IF1 ICache_valid_in.
- IF0_IF1_stall_from_Load  out  1  stall to IF0_IF1 register.
- flush  out  1  squash IF1 and younger this cycle.
- perf_fetch_cnt  out  32  accepted-fetch counter (see Configuration).
- perf_miss_cnt  out  32  not-ready cycle counter (see Configuration).

## Operation
- States: IDLE, FETCH, MISS, DRAIN; 2-bit encoding.
- Registered outputs: IF0_PC, ICache_valid, state.
- Combinational outputs: ICache_req_valid = (state==FETCH || state==MISS); flush = redirect_valid; IF0_IF1_stall_from_Load = stall_from_Load.
- Priority every cycle: redirect > stall > progress.
- IDLE: entered only by reset. Next cycle → FETCH, PC unchanged, ICache_valid=0.
- FETCH:
  - redirect_valid: IF0_PC←redirect_PC&~3, ICache_valid←0. Stay FETCH if icache_req_ready or request not yet outstanding, else → DRAIN.
  - stall_from_Load (no redirect): hold IF0_PC and ICache_valid, stay.
  - icache_req_ready: IF0_PC←IF0_PC+4, ICache_valid←1.
  - else: → MISS, ICache_valid←0, hold PC.
- MISS: hold PC, ICache_valid←0 each cycle.
  - icache_req_ready: IF0_PC←IF0_PC+4, ICache_valid←1, → FETCH.
  - redirect_valid: latch target into IF0_PC, → DRAIN.
  - stall without ready: stay MISS.
- DRAIN: ICache_req_valid=0 (old refill completing). On icache_req_ready: discard the result, ICache_valid←0, → FETCH with the held redirect PC.
- A second redirect in DRAIN overwrites IF0_PC. Stay DRAIN.
- PC arithmetic: 32-bit modulo; 32'hFFFFFFFC+4 = 32'h00000000.
- Async reset mid-operation (any state, any cycle): IF0_PC=RESET_PC, ICache_valid=0, state=IDLE, counters=0. No partial update.

## Timing
- Reset values: IF0_PC=RESET_PC, ICache_valid=0, ICache_req_valid=0 (IDLE), flush=0 with inputs low, counters=0.
- First request: first posedge after rst deassert → FETCH. ICache_req_valid=1 in the second cycle.
- Accepted fetch at posedge n: IF0_PC+4 and ICache_valid=1 visible after edge n.
- Redirect sampled at edge n: flush high during cycle n. Target on IF0_PC after edge n. Request for target in cycle n+1 if not draining.
- Redirect and icache_req_ready in the same FETCH/MISS cycle: redirect wins. The accepted fetch is dropped (ICache_valid←0), no DRAIN.
- Stall and icache_req_ready in the same cycle: stall wins, nothing advances. ICache re-sees the same request next cycle.

## Configuration
- IF_PERF_CNT_EN defined:
  - perf_fetch_cnt increments on each FETCH/MISS→advance (ICache_valid←1).
  - perf_miss_cnt increments on each cycle in MISS or DRAIN.
  - Both counters are 32-bit wrapping and reset to 0.
- IF_PERF_CNT_EN undefined: both ports stay present, tied to 32'b0, no counter flops.

## Test plan
- Reset RESET_PC=32'h1C000000, icache_req_ready=1 constant → IF0_PC sequence 1C000000,1C000004,1C000008. ICache_valid=1 from third cycle.
- icache_req_ready low 3 cycles at PC 1C000010 → state MISS, ICache_valid=0 for 3 cycles, PC held. Advances to 1C000014 on ready. perf_miss_cnt=3 with IF_PERF_CNT_EN.
- redirect_valid with redirect_PC=32'h1C000103 in FETCH → flush for one cycle. IF0_PC=1C000100 next cycle, ICache_valid=0.
- Redirect to 1C000200 during MISS, ready arrives 2 cycles later → DRAIN, ICache_req_valid=0. Then FETCH at 1C000200, no valid slot issued for the old PC.
- stall_from_Load held 2 cycles with ready=1 → PC and ICache_valid frozen, IF0_IF1_stall_from_Load=1. Redirect in a stall cycle still applied.
- PC 32'hFFFFFFFC accepted → next IF0_PC=0. Assert rst mid-MISS → immediately IF0_PC=RESET_PC, ICache_valid=0, IDLE.
